// File: rtl/dcache_pkg.sv
// dcache_pkg: shared sizing and FSM encoding for the 2-way data cache.
//   INDEX_BITS_DEF : default set-index width (sets = 2**INDEX_BITS)
//   TAG_BITS_DEF   : tag width derived from the default index width
//   state_t        : controller states IDLE / RD_MISS / WR_THRU
package dcache_pkg;
   localparam int INDEX_BITS_DEF = 6;
   localparam int TAG_BITS_DEF   = 30 - INDEX_BITS_DEF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;
endpackage

// File: rtl/dcache_way.sv
// dcache_way: one way of the cache -- valid/tag/data arrays plus hit compare.
// Ports:
//   clk, rst      clock, async active-high reset (clears valid bits only)
//   index, tag    set index and tag of the current address
//   fill          install tag + wdata at index and mark valid
//   update        overwrite data at index (write hit)
//   wdata         data for fill/update
//   valid, hit    selected set's valid bit, tag match
//   rdata         selected set's data
module dcache_way #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] index,
   input  logic [TAG_BITS-1:0]   tag,
   input  logic                  fill,
   input  logic                  update,
   input  logic [31:0]           wdata,
   output logic                  valid,
   output logic                  hit,
   output logic [31:0]           rdata
);
   localparam int SETS = 1 << INDEX_BITS;

   logic [SETS-1:0]     valid_q;
   logic [TAG_BITS-1:0] tag_q  [SETS];
   logic [31:0]         data_q [SETS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       valid_q        <= '0;
      else if (fill) valid_q[index] <= 1'b1;
   end

   // Tag/data need no reset: they are qualified by valid. fill/update are
   // never asserted while rst is high because the FSM is held in IDLE.
   always_ff @(posedge clk) begin
      if (fill)           tag_q[index]  <= tag;
      if (fill || update) data_q[index] <= wdata;
   end

   assign valid = valid_q[index];
   assign hit   = valid && (tag_q[index] == tag);
   assign rdata = data_q[index];
endmodule

// File: rtl/dcache_2way_ctrl.sv
// dcache_2way_ctrl: 2-way set-associative, write-through, no-write-allocate
// data cache between the MEM stage and the SRAM controller.
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_r_en, mem_w_en       MEM-stage requests (write wins if both)
//   address, wdata           request address / write data (held while !ready)
//   rdata, ready             read data, 0 = freeze pipeline
//   sram_r_en, sram_w_en     SRAM requests (Moore outputs of the state)
//   sram_address, sram_wdata pass-through of address / wdata
//   sram_rdata, sram_ready   SRAM read data and completion
//   hit_count, miss_count    read-hit / read-miss counters (DCACHE_STATS_EN)
// Optional feature macro: DCACHE_STATS_EN
module dcache_2way_ctrl
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = INDEX_BITS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        sram_r_en,
   output logic        sram_w_en,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
`ifdef DCACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   input  logic        sram_ready
);
   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int SETS     = 1 << INDEX_BITS;

   state_t state, state_nxt;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic [1:0]            way_vld, way_hit, fill, update;
   logic [1:0][31:0]      way_data;
   logic [31:0]           way_wdata;
   logic [SETS-1:0]       lru_q;
   logic                  lru_we, lru_nxt, hit, hit_way, victim;
   logic                  hit_inc, miss_inc;
   logic                  unused_addr;

   assign idx          = address[INDEX_BITS+1:2];
   assign tag          = address[31:INDEX_BITS+2];
   assign unused_addr  = ^address[1:0];
   assign sram_address = address;
   assign sram_wdata   = wdata;
   assign sram_r_en    = (state == RD_MISS);
   assign sram_w_en    = (state == WR_THRU);

   // Fills take the SRAM return data; write hits take the store data.
   assign way_wdata = (state == RD_MISS) ? sram_rdata : wdata;

   genvar w;
   for (w = 0; w < 2; w++) begin : g_way
      dcache_way #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_way (
         .clk    (clk),
         .rst    (rst),
         .index  (idx),
         .tag    (tag),
         .fill   (fill[w]),
         .update (update[w]),
         .wdata  (way_wdata),
         .valid  (way_vld[w]),
         .hit    (way_hit[w]),
         .rdata  (way_data[w])
      );
   end

   assign hit     = |way_hit;
   assign hit_way = ~way_hit[0];
   // Invalid ways are used first (way0 before way1), otherwise the LRU way.
   assign victim  = ~way_vld[0] ? 1'b0 : (~way_vld[1] ? 1'b1 : lru_q[idx]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b1;
      rdata     = '0;
      fill      = '0;
      update    = '0;
      lru_we    = 1'b0;
      lru_nxt   = 1'b0;
      hit_inc   = 1'b0;
      miss_inc  = 1'b0;
      case (state)
         IDLE: begin
            // sram_ready is deliberately not looked at here: the SRAM
            // controller idles with ready=1.
            if (mem_w_en) begin
               ready     = 1'b0;
               state_nxt = WR_THRU;
            end else if (mem_r_en) begin
               if (hit) begin
                  rdata   = way_data[hit_way];
                  lru_we  = 1'b1;
                  lru_nxt = ~hit_way;
                  hit_inc = 1'b1;
               end else begin
                  ready     = 1'b0;
                  state_nxt = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            ready = sram_ready;
            if (sram_ready) begin
               rdata        = sram_rdata;
               fill[victim] = 1'b1;
               lru_we       = 1'b1;
               lru_nxt      = ~victim;
               miss_inc     = 1'b1;
               state_nxt    = IDLE;
            end
         end
         WR_THRU: begin
            ready = sram_ready;
            if (sram_ready) begin
               // Inputs are held stable, so hit still reflects entry state.
               if (hit) begin
                  update[hit_way] = 1'b1;
                  lru_we          = 1'b1;
                  lru_nxt         = ~hit_way;
               end
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         lru_q      <= '0;
      else if (lru_we) lru_q[idx] <= lru_nxt;
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_inc)  hit_count  <= hit_count + 32'd1;
         if (miss_inc) miss_count <= miss_count + 32'd1;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = hit_inc ^ miss_inc;
`endif
endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Testbench for dcache_2way_ctrl: table of directed accesses with a
// behavioural SRAM responder, plus a hand-written reset-during-miss sequence.
module tb_dcache_2way_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en, mem_w_en;
   logic [31:0] address, wdata, rdata;
   logic        ready, sram_r_en, sram_w_en;
   logic [31:0] sram_address, sram_wdata, sram_rdata;
   logic        sram_ready;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dcache_2way_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .address      (address),
      .wdata        (wdata),
      .rdata        (rdata),
      .ready        (ready),
      .sram_r_en    (sram_r_en),
      .sram_w_en    (sram_w_en),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
`ifdef DCACHE_STATS_EN
      .hit_count    (hit_count),
      .miss_count   (miss_count),
`endif
      .sram_ready   (sram_ready)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] sd;   // SRAM return data
      int          lat;  // SRAM-busy cycles before sram_ready
      logic        hit;  // expect zero-latency read hit
      logic [31:0] er;   // expected rdata for reads
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Entered just after a rising edge with all requests low.
   task automatic xact(input vec_t v, input int n);
      string nm;
      int    low_cnt;
      int    bad;
      logic  is_wr;
      nm       = $sformatf("v%0d", n);
      is_wr    = v.wr;
      mem_r_en = v.rd;
      mem_w_en = v.wr;
      address  = v.a;
      wdata    = v.wd;
      sram_rdata = v.sd;
      sram_ready = 1'b1;   // SRAM controller idle
      @(negedge clk);
      if (v.hit) begin
         chk({nm, "_hit_ready"}, {31'd0, ready}, 32'd1);
         chk({nm, "_hit_rdata"}, rdata, v.er);
         chk({nm, "_hit_nosram"}, {30'd0, sram_r_en, sram_w_en}, 32'd0);
         @(posedge clk); #1;
         mem_r_en = 1'b0; mem_w_en = 1'b0;
         return;
      end
      chk({nm, "_entry_ready"}, {31'd0, ready}, 32'd0);
      low_cnt = 1;
      bad     = 0;
      @(posedge clk); #1;
      sram_ready = (v.lat == 0);
      for (int i = 0; i < v.lat; i++) begin
         @(negedge clk);
         if (ready !== 1'b0) bad++;
         if ({sram_r_en, sram_w_en} !== (is_wr ? 2'b01 : 2'b10)) bad++;
         low_cnt++;
         @(posedge clk); #1;
         if (i == v.lat - 1) sram_ready = 1'b1;
      end
      chk({nm, "_wait_bad"}, bad, 0);
      @(negedge clk);
      chk({nm, "_done_ready"}, {31'd0, ready}, 32'd1);
      chk({nm, "_sram_en"}, {30'd0, sram_r_en, sram_w_en}, is_wr ? 32'd1 : 32'd2);
      chk({nm, "_sram_addr"}, sram_address, v.a);
      if (is_wr) chk({nm, "_sram_wdata"}, sram_wdata, v.wd);
      else       chk({nm, "_miss_rdata"}, rdata, v.er);
      chk({nm, "_low_cycles"}, low_cnt, v.lat + 1);
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      @(negedge clk);
      chk({nm, "_en_dropped"}, {30'd0, sram_r_en, sram_w_en}, 32'd0);
      chk({nm, "_idle_ready"}, {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   int exp_hits, exp_miss;

   initial begin
      //          rd    wr    addr          wdata         sram data     lat hit   exp rdata
      tbl[0]  = '{1'b1, 1'b0, 32'h400, 32'h0,        32'hDEADBEEF, 4, 1'b0, 32'hDEADBEEF};
      tbl[1]  = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        0, 1'b1, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 1'b0, 32'h500, 32'h0,        32'h55550500, 2, 1'b0, 32'h55550500};
      tbl[3]  = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        0, 1'b1, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 1'b0, 32'h600, 32'h0,        32'h66660600, 0, 1'b0, 32'h66660600};
      tbl[5]  = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        0, 1'b1, 32'hDEADBEEF};
      tbl[6]  = '{1'b1, 1'b0, 32'h600, 32'h0,        32'h0,        0, 1'b1, 32'h66660600};
      tbl[7]  = '{1'b1, 1'b0, 32'h500, 32'h0,        32'hA5A50500, 1, 1'b0, 32'hA5A50500};
      tbl[8]  = '{1'b1, 1'b0, 32'h400, 32'h0,        32'hCAFE0400, 3, 1'b0, 32'hCAFE0400};
      tbl[9]  = '{1'b0, 1'b1, 32'h400, 32'h12345678, 32'h0,        3, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        0, 1'b1, 32'h12345678};
      tbl[11] = '{1'b1, 1'b0, 32'h500, 32'h0,        32'h0,        0, 1'b1, 32'hA5A50500};
      tbl[12] = '{1'b0, 1'b1, 32'h700, 32'h00000777, 32'h0,        2, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 1'b0, 32'h700, 32'h0,        32'h70707070, 1, 1'b0, 32'h70707070};
      tbl[14] = '{1'b1, 1'b1, 32'h900, 32'h00000099, 32'h0,        1, 1'b0, 32'h0};
      tbl[15] = '{1'b1, 1'b0, 32'h900, 32'h0,        32'h90909090, 2, 1'b0, 32'h90909090};
      tbl[16] = '{1'b1, 1'b0, 32'h700, 32'h0,        32'h0,        0, 1'b1, 32'h70707070};

      rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
      address = '0; wdata = '0; sram_rdata = '0; sram_ready = 1'b1;
      #12;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_sram_en", {30'd0, sram_r_en, sram_w_en}, 32'd0);
`ifdef DCACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      exp_hits = 0; exp_miss = 0;
      for (int i = 0; i < 17; i++) begin
         xact(tbl[i], i);
         if (tbl[i].hit) exp_hits++;
         else if (!tbl[i].wr) exp_miss++;
      end
`ifdef DCACHE_STATS_EN
      chk("hit_count", hit_count, exp_hits);
      chk("miss_count", miss_count, exp_miss);
`endif

      // Reset in the middle of a read miss.
      mem_r_en = 1'b1; address = 32'h800; sram_rdata = 32'hBAD00800; sram_ready = 1'b1;
      @(posedge clk); #1;
      sram_ready = 1'b0;
      @(negedge clk);
      chk("abort_pre_r_en", {31'd0, sram_r_en}, 32'd1);
      #1;
      rst = 1'b1; mem_r_en = 1'b0;
      #1;
      chk("abort_r_en", {31'd0, sram_r_en}, 32'd0);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_rdata", rdata, 32'd0);
`ifdef DCACHE_STATS_EN
      chk("abort_hit_count", hit_count, 32'd0);
      chk("abort_miss_count", miss_count, 32'd0);
`endif
      sram_ready = 1'b1;   // late completion while in reset must be ignored
      @(posedge clk); #1;
      rst = 1'b0;
      xact('{1'b1, 1'b0, 32'h800, 32'h0, 32'h88880800, 2, 1'b0, 32'h88880800}, 100);
      xact('{1'b1, 1'b0, 32'h700, 32'h0, 32'h07070707, 1, 1'b0, 32'h07070707}, 101);
      xact('{1'b1, 1'b0, 32'h800, 32'h0, 32'h0,        0, 1'b1, 32'h88880800}, 102);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
